axi4_lite_bias_loader: RTL
==========================

# axi4_lite_bias_loader

AXI4-Lite master that loads the bias register bank from a 32-bit AXI-Stream source. On `start` it consumes NUM_REGS stream words and writes them to consecutive word addresses of the bias register slave, checking every write response. With readback compiled in, it then reads every register back and compares an XOR checksum. It sits between the DMA/stream source of trained biases and the bias register slave, and raises `done` when the neuron layer may use `b_tdata`.

## Interface
- NUM_REGS, 20, number of 32-bit registers to load (1..32)
- ADDR_WIDTH, 7, AXI4-Lite address width
- BASE_ADDR, 0, byte address of register 0; register i is at BASE_ADDR + 4*i
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion, normal or abort
- error  out  1  sticky; cleared by the next accepted start
- s_axis_tdata  in  32  bias word
- s_axis_tvalid  in  1  word valid
- s_axis_tready  out  1  loader accepts word
- m_axil_awaddr  out  ADDR_WIDTH  write address
- m_axil_awprot  out  3  constant 3'b000
- m_axil_awvalid / m_axil_awready  out / in  1  AW handshake
- m_axil_wdata  out  32  write data
- m_axil_wstrb  out  4  constant 4'hF
- m_axil_wvalid / m_axil_wready  out / in  1  W handshake
- m_axil_bresp  in  2  write response
- m_axil_bvalid / m_axil_bready  in / out  1  B handshake
- m_axil_araddr  out  ADDR_WIDTH  read address
- m_axil_arprot  out  3  constant 3'b000
- m_axil_arvalid / m_axil_arready  out / in  1  AR handshake
- m_axil_rdata  in  32  read data
- m_axil_rresp  in  2  read response
- m_axil_rvalid / m_axil_rready  in / out  1  R handshake

## Operation
- States: IDLE, FETCH, WRITE, WRESP, RADDR, RDATA, DONE. `idx` is the register counter, $clog2(NUM_REGS+1) bits wide.
- IDLE: on start, go to FETCH. Clear error, idx and both checksums.
- FETCH: drive s_axis_tready=1. On tvalid&tready, latch tdata into wdata, XOR it into wsum and go to WRITE.
- WRITE: assert awvalid and wvalid together with awaddr = BASE_ADDR + 4*idx.
  - Each valid drops independently on its own handshake.
  - No valid depends on a ready.
  - When both handshakes are done, go to WRESP.
- bready is high throughout WRITE and WRESP. The slave may pulse bvalid for only one cycle without waiting for bready.
- WRESP: on bvalid:
  - If bresp != 0: set error and go to DONE (abort).
  - Else if idx == NUM_REGS-1: go to RADDR with idx reset to 0 (readback) or go to DONE (no readback).
  - Else: increment idx and go to FETCH.
- RADDR: assert arvalid with araddr = BASE_ADDR + 4*idx until arready, then go to RDATA.
- RDATA: rready=1. On rvalid:
  - XOR rdata into rsum.
  - If rresp != 0: set error.
  - On the last idx: if rsum^rdata != wsum, set error; then go to DONE.
  - Otherwise increment idx and go to RADDR.
- DONE: pulse done for one cycle, return to IDLE. busy is low in IDLE and DONE.
- Stream words arriving outside FETCH are not consumed.

## Timing
- Reset values: all valid/ready outputs 0, busy 0, done 0, error 0, awaddr/araddr/wdata 0, state IDLE.
- Reset mid-operation drops every valid immediately, without waiting for AXI completion.
- start at cycle t: busy=1 and tready=1 at t+1.
- Word accepted at cycle c: awvalid and wvalid are high at c+1.
- Against a slave with 1-cycle ready and 1-cycle bvalid, one write costs about 5 cycles.
- done is asserted the cycle after the final B (or R) handshake.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. The bench must keep BASE_ADDR + 4*NUM_REGS in range.

## Configuration
- BIAS_LOADER_READBACK_EN defined: RADDR/RDATA states and checksum compare are present.
- BIAS_LOADER_READBACK_EN undefined:
  - arvalid, rready and araddr are tied 0 and rsum is absent.
  - The last good B response goes directly to DONE.

## Test plan
- Load 20 words 0x1000_0000+i, slave ready immediately, bresp=0 -> 20 writes to addresses 0x00..0x4C with matching wdata, one done pulse, error=0. The slave's b_tdata[32*i+:32] equals 0x1000_0000+i.
- Throttle the stream (tvalid every 3rd cycle) and delay wready by 2 cycles after awready -> awvalid holds until accepted, addresses and data stay correct, no duplicate writes.
- Slave returns bresp=2 on register 5 -> error=1, done pulses after the 6th B, only 6 writes issued, busy drops.
- Readback enabled, slave corrupts register 7 on read (bit 0 flipped) -> error=1 after the 20th read, done pulses once.
- Assert RST while awvalid=1 mid-load, then release and start again -> outputs return to reset values in the same cycle, and the new load of 20 words completes with error=0.

Source files
------------

// File: rtl/axi4_lite_bias_loader.sv
// AXI4-Lite master that copies NUM_REGS AXI-Stream words into the bias register bank.
// Optional readback with XOR checksum compare is enabled by BIAS_LOADER_READBACK_EN.
module axi4_lite_bias_loader #(
   parameter int unsigned               NUM_REGS   = 20,
   parameter int unsigned               ADDR_WIDTH = 7,
   parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR  = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   input  logic [31:0]           s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [31:0]           m_axil_wdata,
   output logic [3:0]            m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [31:0]           m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   localparam int unsigned      IDX_W    = $clog2(NUM_REGS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      StIdle, StFetch, StWrite, StWresp, StRaddr, StRdata, StDone
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [31:0]             wsum_q, wsum_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic                    error_q, error_d;
   logic [ADDR_WIDTH-1:0]   reg_addr;

   assign reg_addr = BASE_ADDR + ADDR_WIDTH'({idx_q, 2'b00});

   assign busy           = (state_q != StIdle) && (state_q != StDone);
   assign done           = (state_q == StDone);
   assign error          = error_q;
   assign s_axis_tready  = (state_q == StFetch);
   // Valids come from state and handshake history only, never from a ready.
   assign m_axil_awvalid = (state_q == StWrite) && !aw_done_q;
   assign m_axil_wvalid  = (state_q == StWrite) && !w_done_q;
   assign m_axil_awaddr  = m_axil_awvalid ? reg_addr : '0;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = 4'hF;
   assign m_axil_bready  = (state_q == StWrite) || (state_q == StWresp);
   assign m_axil_arprot  = 3'b000;

`ifdef BIAS_LOADER_READBACK_EN
   logic [31:0] rsum_q, rsum_d;

   assign m_axil_arvalid = (state_q == StRaddr);
   assign m_axil_araddr  = m_axil_arvalid ? reg_addr : '0;
   assign m_axil_rready  = (state_q == StRdata);
`else
   logic unused_rd;

   assign m_axil_arvalid = 1'b0;
   assign m_axil_araddr  = '0;
   assign m_axil_rready  = 1'b0;
   assign unused_rd      = ^{m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid, wsum_q};
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      wsum_d    = wsum_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      error_d   = error_q;
`ifdef BIAS_LOADER_READBACK_EN
      rsum_d    = rsum_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
               error_d = 1'b0;
               idx_d   = '0;
               wsum_d  = '0;
`ifdef BIAS_LOADER_READBACK_EN
               rsum_d  = '0;
`endif
            end
         end
         StFetch: begin
            if (s_axis_tvalid) begin
               wdata_d   = s_axis_tdata;
               wsum_d    = wsum_q ^ s_axis_tdata;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = StWrite;
            end
         end
         StWrite: begin
            aw_done_d = aw_done_q | m_axil_awready;
            w_done_d  = w_done_q | m_axil_wready;
            if (aw_done_d && w_done_d) state_d = StWresp;
         end
         StWresp: begin
            if (m_axil_bvalid) begin
               if (m_axil_bresp != 2'b00) begin
                  error_d = 1'b1;
                  state_d = StDone;
               end else if (idx_q == LAST_IDX) begin
`ifdef BIAS_LOADER_READBACK_EN
                  idx_d   = '0;
                  state_d = StRaddr;
`else
                  state_d = StDone;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StFetch;
               end
            end
         end
`ifdef BIAS_LOADER_READBACK_EN
         StRaddr: begin
            if (m_axil_arready) state_d = StRdata;
         end
         StRdata: begin
            if (m_axil_rvalid) begin
               rsum_d = rsum_q ^ m_axil_rdata;
               if (m_axil_rresp != 2'b00) error_d = 1'b1;
               if (idx_q == LAST_IDX) begin
                  if (rsum_d != wsum_q) error_d = 1'b1;
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StRaddr;
               end
            end
         end
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         wdata_q   <= '0;
         wsum_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         error_q   <= 1'b0;
`ifdef BIAS_LOADER_READBACK_EN
         rsum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         wsum_q    <= wsum_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         error_q   <= error_d;
`ifdef BIAS_LOADER_READBACK_EN
         rsum_q    <= rsum_d;
`endif
      end
   end

endmodule
